// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card target: R1/R7 responses and CMD17 block reads
// Optional feature macro: SDSPI_CRC16_EN (CRC16-CCITT over read data, else CRC bytes are 0xFF)
module sd_spi_responder #(
   parameter int ADDR_W        = 18,
   parameter int RESP_DELAY    = 1,
   parameter int DATA_DELAY    = 2,
   parameter int INIT_BUSY_CNT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sd_clk,
   input  logic              sd_cs,
   input  logic              sd_mosi,
   output logic              sd_miso,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              in_idle,
   output logic              busy,
   output logic [5:0]        last_cmd
);
   localparam int         SECT_W   = ADDR_W - 9;
   localparam logic [7:0] NCR_LAST = 8'(RESP_DELAY - 1);
   localparam logic [7:0] GAP_LAST = 8'(DATA_DELAY - 1);
   localparam logic [7:0] BUSY_N   = 8'(INIT_BUSY_CNT);

   typedef enum logic [2:0] {HUNT, CMD_RX, NCR, RESP, DGAP, TOKEN, DATA, CRC} state_t;

   logic [2:0]        sclk_q;
   logic [1:0]        scs_q, smosi_q;
   logic              rise, fall, cs_s;
   state_t            state_q, state_d;
   logic [2:0]        bit_q, bit_d, left_q, left_d;
   logic [7:0]        rx_q, rx_d, tx_q, tx_d, nxt_q, nxt_d, cnt_q, cnt_d;
   logic [7:0]        acnt_q, acnt_d, pf_q, pf_d;
   logic              ld_q, ld_d, app_q, app_d, idle_q, idle_d, dgo_q, dgo_d;
   logic [5:0]        idx_q, idx_d, last_q, last_d;
   logic [31:0]       arg_q, arg_d, resp_q, resp_d;
   logic [SECT_W-1:0] sect_q, sect_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d, rd_dly_q;
   logic [9:0]        dcnt_q, dcnt_d;
   logic [15:0]       crc_out;
   logic [7:0]        rx_byte, r1;
   logic              go_tok;

`ifdef SDSPI_CRC16_EN
   logic [15:0] crc_q, crc_d;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   assign crc_out = crc_q;
`else
   assign crc_out = 16'hFFFF;
`endif

   // sclk_q[1] is the synchronised level, sclk_q[2] its previous value; mosi shares the same latency
   assign rise = sclk_q[1] & ~sclk_q[2];
   assign fall = ~sclk_q[1] & sclk_q[2];
   assign cs_s = scs_q[1];

   assign sd_miso  = tx_q[7];
   assign mem_addr = addr_q;
   assign mem_rd   = rd_q;
   assign in_idle  = idle_q;
   assign busy     = (state_q != HUNT);
   assign last_cmd = last_q;

   always_comb begin
      state_d = state_q;  bit_d  = bit_q;  rx_d   = rx_q;   tx_d   = tx_q;
      nxt_d   = nxt_q;    ld_d   = ld_q;   cnt_d  = cnt_q;  idx_d  = idx_q;
      arg_d   = arg_q;    app_d  = app_q;  idle_d = idle_q; acnt_d = acnt_q;
      last_d  = last_q;   resp_d = resp_q; left_d = left_q; dgo_d  = dgo_q;
      sect_d  = sect_q;   addr_d = addr_q; rd_d   = 1'b0;   dcnt_d = dcnt_q;
      pf_d    = rd_dly_q ? mem_rdata : pf_q;
`ifdef SDSPI_CRC16_EN
      crc_d   = crc_q;
`endif
      rx_byte = {rx_q[6:0], smosi_q[1]};
      r1      = 8'hFF;
      go_tok  = 1'b0;
      // sd_cs high overrides any sd_clk edge seen in the same cycle
      if (cs_s) begin
         state_d = HUNT;
         bit_d   = '0;
         tx_d    = 8'hFF;
         ld_d    = 1'b0;
         cnt_d   = '0;
      end else begin
         if (fall) begin
            if (ld_q) begin
               tx_d = nxt_q;
               ld_d = 1'b0;
            end else begin
               tx_d = {tx_q[6:0], 1'b1};
            end
         end
         if (rise) begin
            bit_d = bit_q + 3'd1;
            rx_d  = rx_byte;
            if (bit_q == 3'd7) begin
               ld_d  = 1'b1;
               nxt_d = 8'hFF;
               case (state_q)
                  HUNT: if (rx_byte[7:6] == 2'b01) begin
                     idx_d   = rx_byte[5:0];
                     cnt_d   = '0;
                     state_d = CMD_RX;
                  end
                  CMD_RX: if (cnt_q == 8'd4) begin
                     last_d  = idx_q;
                     cnt_d   = '0;
                     state_d = NCR;
                  end else begin
                     arg_d = {arg_q[23:0], rx_byte};
                     cnt_d = cnt_q + 8'd1;
                  end
                  NCR: if (cnt_q == NCR_LAST) begin
                     app_d  = 1'b0;
                     left_d = '0;
                     dgo_d  = 1'b0;
                     case (idx_q)
                        6'd0: begin
                           idle_d = 1'b1;
                           acnt_d = '0;
                           r1     = 8'h01;
                        end
                        6'd8: begin
                           r1     = {7'b0, idle_q};
                           resp_d = {20'h0, arg_q[11:0]};
                           left_d = 3'd4;
                        end
                        6'd55: begin
                           r1    = {7'b0, idle_q};
                           app_d = 1'b1;
                        end
                        6'd41: if (!app_q) begin
                           r1 = {5'b0, 1'b1, 1'b0, idle_q};
                        end else if (acnt_q < BUSY_N) begin
                           r1     = 8'h01;
                           acnt_d = acnt_q + 8'd1;
                        end else begin
                           r1     = 8'h00;
                           idle_d = 1'b0;
                        end
                        6'd17: if (idle_q) begin
                           r1 = 8'h05;
                        end else if ((arg_q >> SECT_W) != 32'd0) begin
                           r1 = 8'h40;
                        end else begin
                           r1     = 8'h00;
                           dgo_d  = 1'b1;
                           sect_d = arg_q[SECT_W-1:0];
                        end
                        default: r1 = {5'b0, 1'b1, 1'b0, idle_q};
                     endcase
                     nxt_d   = r1;
                     state_d = RESP;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
                  RESP: if (left_q != 3'd0) begin
                     nxt_d  = resp_q[31:24];
                     resp_d = {resp_q[23:0], 8'h00};
                     left_d = left_q - 3'd1;
                  end else if (!dgo_q) begin
                     state_d = HUNT;
                  end else if (DATA_DELAY == 0) begin
                     go_tok = 1'b1;
                  end else begin
                     state_d = DGAP;
                     cnt_d   = '0;
                  end
                  DGAP: if (cnt_q == GAP_LAST) go_tok = 1'b1;
                        else cnt_d = cnt_q + 8'd1;
                  TOKEN, DATA: if (state_q == DATA && dcnt_q == 10'd512) begin
                     state_d = CRC;
                     cnt_d   = '0;
                     nxt_d   = crc_out[15:8];
                  end else begin
                     // hand out the prefetched byte and fetch the following one right away
                     state_d     = DATA;
                     nxt_d       = pf_q;
                     dcnt_d      = dcnt_q + 10'd1;
                     addr_d[8:0] = addr_q[8:0] + 9'd1;
                     rd_d        = (dcnt_q != 10'd511);
`ifdef SDSPI_CRC16_EN
                     crc_d       = crc16_byte(crc_q, pf_q);
`endif
                  end
                  CRC: if (cnt_q == 8'd0) begin
                     nxt_d = crc_out[7:0];
                     cnt_d = 8'd1;
                  end else begin
                     state_d = HUNT;
                  end
                  default: state_d = HUNT;
               endcase
               if (go_tok) begin
                  nxt_d   = 8'hFE;
                  state_d = TOKEN;
                  addr_d  = {sect_q, 9'd0};
                  rd_d    = 1'b1;
                  dcnt_d  = '0;
`ifdef SDSPI_CRC16_EN
                  crc_d   = '0;
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_q  <= '0;      scs_q  <= 2'b11;  smosi_q <= 2'b11;
         state_q <= HUNT;    bit_q  <= '0;     rx_q    <= 8'hFF;  tx_q   <= 8'hFF;
         nxt_q   <= 8'hFF;   ld_q   <= 1'b0;   cnt_q   <= '0;     idx_q  <= '0;
         arg_q   <= '0;      app_q  <= 1'b0;   idle_q  <= 1'b1;   acnt_q <= '0;
         last_q  <= '0;      resp_q <= '0;     left_q  <= '0;     dgo_q  <= 1'b0;
         sect_q  <= '0;      addr_q <= '0;     rd_q    <= 1'b0;   rd_dly_q <= 1'b0;
         pf_q    <= '0;      dcnt_q <= '0;
`ifdef SDSPI_CRC16_EN
         crc_q   <= '0;
`endif
      end else begin
         sclk_q  <= {sclk_q[1:0], sd_clk};
         scs_q   <= {scs_q[0], sd_cs};
         smosi_q <= {smosi_q[0], sd_mosi};
         state_q <= state_d; bit_q  <= bit_d;  rx_q    <= rx_d;   tx_q   <= tx_d;
         nxt_q   <= nxt_d;   ld_q   <= ld_d;   cnt_q   <= cnt_d;  idx_q  <= idx_d;
         arg_q   <= arg_d;   app_q  <= app_d;  idle_q  <= idle_d; acnt_q <= acnt_d;
         last_q  <= last_d;  resp_q <= resp_d; left_q  <= left_d; dgo_q  <= dgo_d;
         sect_q  <= sect_d;  addr_q <= addr_d; rd_q    <= rd_d;   rd_dly_q <= rd_q;
         pf_q    <= pf_d;    dcnt_q <= dcnt_d;
`ifdef SDSPI_CRC16_EN
         crc_q   <= crc_d;
`endif
      end
   end
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - randomized self-checking bench for sd_spi_responder
// Expected byte streams come from a command-level card model and a computed backing memory.
module tb_sd_spi_responder;
   localparam int ADDR_W = 18, RESP_DELAY = 1, DATA_DELAY = 2, INIT_BUSY_CNT = 2;
   localparam int H = 3;  // sd_clk half period in clk cycles

   logic              clk = 1'b0, reset = 1'b1, sd_clk = 1'b0, sd_cs = 1'b1, sd_mosi = 1'b1;
   logic              sd_miso, mem_rd, in_idle, busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata = 8'h00;
   logic [5:0]        last_cmd;

   int                n_checks = 0, n_errors = 0;
   logic              m_idle = 1'b1, m_app = 1'b0;
   int                m_acnt = 0;
   logic [7:0]        exp_q[$];
   logic [ADDR_W-1:0] rd_log[$];

   always #5 clk = ~clk;

   sd_spi_responder #(.ADDR_W(ADDR_W), .RESP_DELAY(RESP_DELAY), .DATA_DELAY(DATA_DELAY),
                      .INIT_BUSY_CNT(INIT_BUSY_CNT)) dut (
      .clk(clk), .reset(reset), .sd_clk(sd_clk), .sd_cs(sd_cs), .sd_mosi(sd_mosi),
      .sd_miso(sd_miso), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .in_idle(in_idle), .busy(busy), .last_cmd(last_cmd));

   function automatic logic [7:0] mem_fn(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[16:9];
   endfunction

   always @(posedge clk) if (mem_rd) begin
      mem_rdata <= mem_fn(mem_addr);
      rd_log.push_back(mem_addr);
   end

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) r = (r[15] ^ b[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         sd_mosi = tx[i];
         wclk(H);
         rx[i]  = sd_miso;
         sd_clk = 1'b1;
         wclk(H);
         sd_clk = 1'b0;
      end
   endtask

   // Card behaviour at command level: full expected MISO stream following the command frame
   task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
      logic        was_app;
      logic [15:0] crc;
      logic [7:0]  b;
      exp_q.delete();
      repeat (RESP_DELAY) exp_q.push_back(8'hFF);
      was_app = m_app;
      m_app   = 1'b0;
      if (idx == 6'd0) begin
         m_idle = 1'b1; m_acnt = 0; exp_q.push_back(8'h01);
      end else if (idx == 6'd8) begin
         exp_q.push_back({7'b0, m_idle}); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
         exp_q.push_back({4'h0, arg[11:8]}); exp_q.push_back(arg[7:0]);
      end else if (idx == 6'd55) begin
         exp_q.push_back({7'b0, m_idle}); m_app = 1'b1;
      end else if (idx == 6'd41 && was_app) begin
         if (m_acnt < INIT_BUSY_CNT) begin m_acnt++; exp_q.push_back(8'h01); end
         else begin m_idle = 1'b0; exp_q.push_back(8'h00); end
      end else if (idx == 6'd17) begin
         if (m_idle) exp_q.push_back(8'h05);
         else if (arg >= 32'd512) exp_q.push_back(8'h40);
         else begin
            exp_q.push_back(8'h00);
            repeat (DATA_DELAY) exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFE);
            crc = 16'h0;
            for (int j = 0; j < 512; j++) begin
               b = mem_fn({arg[8:0], 9'(j)});
               exp_q.push_back(b);
               crc = crc_ref(crc, b);
            end
`ifdef SDSPI_CRC16_EN
            exp_q.push_back(crc[15:8]); exp_q.push_back(crc[7:0]);
`else
            exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
`endif
         end
      end else begin
         exp_q.push_back(8'h04 | {7'b0, m_idle});
      end
   endtask

   // limit < 0: take the whole response; otherwise raise sd_cs after 'limit' bytes
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int limit);
      logic [7:0] fr[6];
      logic [7:0] rx;
      int         n;
      fr[0] = {2'b01, idx};
      fr[1] = arg[31:24]; fr[2] = arg[23:16]; fr[3] = arg[15:8]; fr[4] = arg[7:0];
      fr[5] = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'hFF;
      model_cmd(idx, arg);
      for (int i = 0; i < 6; i++) begin
         xfer(fr[i], rx);
         check("frame_tx_ff", rx, 8'hFF);
      end
      check("last_cmd", last_cmd, idx);
      check("busy_frame", busy, 1);
      n = (limit >= 0 && limit < exp_q.size()) ? limit : exp_q.size();
      for (int i = 0; i < n; i++) begin
         xfer(8'hFF, rx);
         check($sformatf("cmd%0d_byte%0d", idx, i), rx, exp_q[i]);
      end
      if (n == exp_q.size()) begin
         check("busy_done", busy, 0);
         xfer(8'hFF, rx);
         check("hunt_ff", rx, 8'hFF);
      end else begin
         sd_cs = 1'b1;
         wclk(3);
         check("abort_miso", sd_miso, 1);
         check("abort_busy", busy, 0);
         wclk(2);
         sd_cs = 1'b0;
         wclk(4);
      end
      check("in_idle", in_idle, m_idle);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         bad;
      int         pick;
      logic [7:0] rx;
      logic [31:0] arg;

      wclk(4);
      reset = 1'b0;
      wclk(2);
      check("reset_in_idle", in_idle, 1);
      check("reset_busy", busy, 0);
      check("reset_last_cmd", last_cmd, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_mem_rd", mem_rd, 0);
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         sd_clk = 1'b1; wclk(H); if (sd_miso !== 1'b1) bad++;
         sd_clk = 1'b0; wclk(H); if (sd_miso !== 1'b1) bad++;
      end
      check("cs_high_miso_not_one", bad, 0);
      check("cs_high_busy", busy, 0);

      sd_cs = 1'b0;
      wclk(4);
      run_cmd(6'd0, 32'h0, -1);
      run_cmd(6'd8, 32'h1AA, -1);
      run_cmd(6'd5, 32'h0, -1);
      for (int k = 0; k < 3; k++) begin
         run_cmd(6'd55, 32'h0, -1);
         run_cmd(6'd41, 32'h4000_0000, -1);
      end
      check("idle_after_init", in_idle, 0);

      rd_log.delete();
      run_cmd(6'd17, 32'h0, -1);
      check("rd_count", rd_log.size(), 512);
      bad = 0;
      foreach (rd_log[i]) if (rd_log[i] !== ADDR_W'(i)) bad++;
      check("rd_addr_seq_bad", bad, 0);

      run_cmd(6'd17, 32'h0, RESP_DELAY + 1 + DATA_DELAY + 1 + 101);
      rd_log.delete();
      run_cmd(6'd17, 32'h1, RESP_DELAY + 1 + DATA_DELAY + 1 + 20);
      check("sector1_first_addr", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hFFFF_FFFF, 512);
      run_cmd(6'd17, 32'd512, -1);

      for (int k = 0; k < 20; k++) begin
         pick = $urandom_range(0, 6);
         arg  = $urandom;
         case (pick)
            0: run_cmd(6'd0, arg, -1);
            1: run_cmd(6'd8, arg, -1);
            2: run_cmd(6'd55, arg, -1);
            3: run_cmd(6'd41, arg, -1);
            4: run_cmd(6'd17, 32'($urandom_range(0, 511)),
                       RESP_DELAY + 1 + DATA_DELAY + 1 + $urandom_range(1, 8));
            5: run_cmd(6'd17, 32'd512 + {9'd0, arg[22:0]}, -1);
            default: run_cmd(6'($urandom_range(0, 63)), arg, RESP_DELAY + 1 + DATA_DELAY + 4);
         endcase
      end

      run_cmd(6'd55, 32'h0, -1);
      xfer(8'h69, rx);
      xfer(8'h40, rx);
      reset = 1'b1;
      wclk(1);
      check("midreset_in_idle", in_idle, 1);
      check("midreset_busy", busy, 0);
      check("midreset_last_cmd", last_cmd, 0);
      check("midreset_miso", sd_miso, 1);
      reset = 1'b0;
      m_idle = 1'b1; m_acnt = 0; m_app = 1'b0;
      wclk(4);
      run_cmd(6'd8, 32'h2A5, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
